conv_tap_scheduler: RTL and testbench

Sequences one output-channel-unrolled convolution engine (start/done, `kh`/`kw`, tile-window inputs) through every kernel tap of a KxK convolution on one output tile. For each tap it computes the input-row/column window, launches the engine, and waits for its completion. It pulses `done` once the full tap sweep has finished. It sits between the layer-level controller and the engine; the first tap is always (0,0), so the engine's accumulator-clear on that tap is honoured.

---
 rtl/conv_tap_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_conv_tap_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tap_scheduler.sv
// conv_tap_scheduler
//   Steps an output-channel-unrolled convolution engine through every kernel
//   tap of a KxK convolution on one output tile. For each tap it sets up the
//   input-row/column window, launches the engine for one cycle and waits for
//   the engine's completion edge. A one-cycle `done` pulse marks the end of
//   the sweep. Tap (0,0) always runs first so the engine clears its
//   accumulator on it.
//
// Optional feature macro: CONV_TAP_SCHED_TAP_MASK_EN
//   When defined, a 9-bit `tap_mask` input (bit = kh*3+kw) selects which taps
//   run. Disabled taps are skipped without a launch. Bit 0 is ignored, and so
//   are bits for taps outside the kernel.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   start               sweep request, only accepted while idle
//   k_last              kernel side minus 1 (3 is rejected)
//   ic_last             last input-channel word index, passed to the engine
//   oh_last, ow_last    last output row/column within the tile
//   tap_mask            per-tap enable (only with the macro above)
//   uo_start            one-cycle engine launch
//   uo_kh, uo_kw        current tap
//   uo_ic_last          latched ic_last
//   uo_ih_low_*         engine input-row window (start/last)
//   uo_iw_low_*         engine input-column window (start/last)
//   uo_done             engine completion; only a rising edge counts
//   busy                high whenever not idle
//   done                one-cycle pulse when a sweep completes normally
//   err                 sticky; set by a rejected config or a watchdog
//                       timeout, cleared by the next accepted start

module conv_tap_scheduler #(
  parameter int IC_WIDTH        = 5,
  parameter int TILE_SIZE_WIDTH = 5,
  parameter int TIMEOUT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 k_last,
  input  logic [IC_WIDTH-1:0]        ic_last,
  input  logic [TILE_SIZE_WIDTH-1:0] oh_last,
  input  logic [TILE_SIZE_WIDTH-1:0] ow_last,
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
  input  logic [8:0]                 tap_mask,
`endif
  output logic                       uo_start,
  output logic [1:0]                 uo_kh,
  output logic [1:0]                 uo_kw,
  output logic [IC_WIDTH-1:0]        uo_ic_last,
  output logic [TILE_SIZE_WIDTH-1:0] uo_ih_low_start,
  output logic [TILE_SIZE_WIDTH-1:0] uo_ih_low_last,
  output logic [TILE_SIZE_WIDTH-1:0] uo_iw_low_start,
  output logic [TILE_SIZE_WIDTH-1:0] uo_iw_low_last,
  input  logic                       uo_done,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int TW = TILE_SIZE_WIDTH;

  // The counter value seen in the WAIT cycle whose increment reaches
  // all-ones; the timeout fires in that cycle.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_TERM =
    {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Latched configuration
  logic [1:0]          k_last_reg;
  logic [IC_WIDTH-1:0] ic_last_reg;
  logic [TW-1:0]       oh_last_reg;
  logic [TW-1:0]       ow_last_reg;
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
  logic [8:0]          tap_mask_reg;
`endif

  // Current tap and engine window
  logic [1:0]    kh_reg, kw_reg;
  logic [TW-1:0] ih_start_reg, ih_last_reg;
  logic [TW-1:0] iw_start_reg, iw_last_reg;

  // Completion edge detector, watchdog and error flag
  logic                     done_prev_reg;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt_reg;
  logic                     err_reg;

  // FSM side-effect strobes
  logic accept_next;
  logic reject_next;
  logic timeout_next;
  logic advance_next;

  // ---------------------------------------------------------------------
  // Config legality: the widest window row/column is oh_last+k_last, which
  // must fit in the tile coordinate. One extra bit catches the overflow.
  // ---------------------------------------------------------------------
  logic [TW:0] oh_sum, ow_sum;
  logic        cfg_legal;

  assign oh_sum    = {1'b0, oh_last} + (TW+1)'(k_last);
  assign ow_sum    = {1'b0, ow_last} + (TW+1)'(k_last);
  assign cfg_legal = (k_last != 2'd3) && !oh_sum[TW] && !ow_sum[TW];

  // ---------------------------------------------------------------------
  // Tap enables, one per linear tap index kh*3+kw
  // ---------------------------------------------------------------------
  logic [8:0] tap_en;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam logic [1:0] TAP_KH = 2'(gi / 3);
      localparam logic [1:0] TAP_KW = 2'(gi % 3);
      logic in_range;
      assign in_range = (TAP_KH <= k_last_reg) && (TAP_KW <= k_last_reg);
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
      assign tap_en[gi] = in_range && tap_mask_reg[gi];
`else
      assign tap_en[gi] = in_range;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Next enabled tap after the current one (lowest index above it)
  // ---------------------------------------------------------------------
  logic [3:0] cur_idx;
  logic [3:0] tap_next_idx;
  logic       tap_next_found;
  logic [1:0] tap_next_kh, tap_next_kw;

  assign cur_idx = (4'(kh_reg) << 1) + 4'(kh_reg) + 4'(kw_reg);

  always_comb begin
    tap_next_found = 1'b0;
    tap_next_idx   = 4'd0;
    // Descending scan so the lowest qualifying index is the one kept.
    for (int j = 8; j >= 0; j--) begin
      if ((4'(j) > cur_idx) && tap_en[j]) begin
        tap_next_found = 1'b1;
        tap_next_idx   = 4'(j);
      end
    end
  end

  always_comb begin
    tap_next_kh = 2'd0;
    tap_next_kw = 2'd0;
    case (tap_next_idx)
      4'd1:    begin tap_next_kh = 2'd0; tap_next_kw = 2'd1; end
      4'd2:    begin tap_next_kh = 2'd0; tap_next_kw = 2'd2; end
      4'd3:    begin tap_next_kh = 2'd1; tap_next_kw = 2'd0; end
      4'd4:    begin tap_next_kh = 2'd1; tap_next_kw = 2'd1; end
      4'd5:    begin tap_next_kh = 2'd1; tap_next_kw = 2'd2; end
      4'd6:    begin tap_next_kh = 2'd2; tap_next_kw = 2'd0; end
      4'd7:    begin tap_next_kh = 2'd2; tap_next_kw = 2'd1; end
      4'd8:    begin tap_next_kh = 2'd2; tap_next_kw = 2'd2; end
      default: begin tap_next_kh = 2'd0; tap_next_kw = 2'd0; end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    accept_next  = 1'b0;
    reject_next  = 1'b0;
    timeout_next = 1'b0;
    advance_next = 1'b0;
    uo_start     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (cfg_legal) begin
            accept_next = 1'b1;
            state_next  = S_LAUNCH;
          end else begin
            reject_next = 1'b1;
          end
        end
      end

      S_LAUNCH: begin
        uo_start   = 1'b1;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        // Completion is checked first so it wins over a simultaneous
        // watchdog terminal count.
        if (uo_done && !done_prev_reg) begin
          state_next = S_NEXT;
        end else if (wd_cnt_reg == WD_TERM) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end
      end

      S_NEXT: begin
        if (tap_next_found) begin
          advance_next = 1'b1;
          state_next   = S_LAUNCH;
        end else begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Configuration, tap/window registers, edge detector, watchdog, error
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      k_last_reg    <= 2'd0;
      ic_last_reg   <= '0;
      oh_last_reg   <= '0;
      ow_last_reg   <= '0;
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
      tap_mask_reg  <= 9'd1;
`endif
      kh_reg        <= 2'd0;
      kw_reg        <= 2'd0;
      ih_start_reg  <= '0;
      ih_last_reg   <= '0;
      iw_start_reg  <= '0;
      iw_last_reg   <= '0;
      done_prev_reg <= 1'b0;
      wd_cnt_reg    <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (accept_next) begin
        k_last_reg   <= k_last;
        ic_last_reg  <= ic_last;
        oh_last_reg  <= oh_last;
        ow_last_reg  <= ow_last;
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
        // Tap (0,0) is forced on: it carries the accumulator clear.
        tap_mask_reg <= tap_mask | 9'd1;
`endif
        kh_reg       <= 2'd0;
        kw_reg       <= 2'd0;
        ih_start_reg <= '0;
        ih_last_reg  <= oh_last;
        iw_start_reg <= '0;
        iw_last_reg  <= ow_last;
        err_reg      <= 1'b0;
      end

      if (reject_next || timeout_next) begin
        err_reg <= 1'b1;
      end

      // The window moves in NEXT so it is already valid in LAUNCH and stays
      // put until the following LAUNCH.
      if (advance_next) begin
        kh_reg       <= tap_next_kh;
        kw_reg       <= tap_next_kw;
        ih_start_reg <= TW'(tap_next_kh);
        ih_last_reg  <= TW'(tap_next_kh) + oh_last_reg;
        iw_start_reg <= TW'(tap_next_kw);
        iw_last_reg  <= TW'(tap_next_kw) + ow_last_reg;
      end

      // Preloading 1 in LAUNCH hides a completion level still high from the
      // previous tap; the engine must drop and re-raise uo_done.
      if (state_reg == S_LAUNCH) begin
        done_prev_reg <= 1'b1;
        wd_cnt_reg    <= '0;
      end else if (state_reg == S_WAIT) begin
        done_prev_reg <= uo_done;
        wd_cnt_reg    <= wd_cnt_reg + 1'b1;
      end
    end
  end

  assign uo_kh           = kh_reg;
  assign uo_kw           = kw_reg;
  assign uo_ic_last      = ic_last_reg;
  assign uo_ih_low_start = ih_start_reg;
  assign uo_ih_low_last  = ih_last_reg;
  assign uo_iw_low_start = iw_start_reg;
  assign uo_iw_low_last  = iw_last_reg;
  assign err             = err_reg;

endmodule

// File: tb/tb_conv_tap_scheduler.sv
// Directed bench for conv_tap_scheduler. A main instance runs against an
// engine model that answers 20 cycles after each launch (pulse or held-high
// level); a second instance with a 4-bit watchdog covers timeout behaviour.
module tb_conv_tap_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] k_last = 2'd0;
  logic [4:0] ic_last = 5'd0;
  logic [4:0] oh_last = 5'd0;
  logic [4:0] ow_last = 5'd0;
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
  logic [8:0] tap_mask = 9'h1FF;
`endif

  logic       uo_start, uo_done, busy, done, err;
  logic [1:0] uo_kh, uo_kw;
  logic [4:0] uo_ic_last, uo_ih_low_start, uo_ih_low_last;
  logic [4:0] uo_iw_low_start, uo_iw_low_last;

  logic       wd_start = 1'b0;
  logic       wd_uo_done = 1'b0;
  logic       wd_uo_start, wd_busy, wd_done, wd_err;
  logic [1:0] wd_uo_kh, wd_uo_kw;
  logic [4:0] wd_ic_last, wd_ih_start, wd_ih_last, wd_iw_start, wd_iw_last;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int launch_cnt = 0;
  int wd_done_cnt = 0;

  // Engine model
  logic [7:0] eng_cnt = 8'd0;
  logic       eng_hi = 1'b0;
  logic       eng_level = 1'b0;

  always #5 clk = ~clk;

  conv_tap_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .k_last(k_last), .ic_last(ic_last),
    .oh_last(oh_last), .ow_last(ow_last),
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
    .tap_mask(tap_mask),
`endif
    .uo_start(uo_start), .uo_kh(uo_kh), .uo_kw(uo_kw), .uo_ic_last(uo_ic_last),
    .uo_ih_low_start(uo_ih_low_start), .uo_ih_low_last(uo_ih_low_last),
    .uo_iw_low_start(uo_iw_low_start), .uo_iw_low_last(uo_iw_low_last),
    .uo_done(uo_done), .busy(busy), .done(done), .err(err)
  );

  conv_tap_scheduler #(.TIMEOUT_WIDTH(4)) dut_wd (
    .clk(clk), .rst(rst), .start(wd_start), .k_last(k_last), .ic_last(ic_last),
    .oh_last(oh_last), .ow_last(ow_last),
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
    .tap_mask(tap_mask),
`endif
    .uo_start(wd_uo_start), .uo_kh(wd_uo_kh), .uo_kw(wd_uo_kw), .uo_ic_last(wd_ic_last),
    .uo_ih_low_start(wd_ih_start), .uo_ih_low_last(wd_ih_last),
    .uo_iw_low_start(wd_iw_start), .uo_iw_low_last(wd_iw_last),
    .uo_done(wd_uo_done), .busy(wd_busy), .done(wd_done), .err(wd_err)
  );

  // eng_cnt = cycles since the last launch (saturating). Pulse mode: one-cycle
  // uo_done at count 20. Level mode: high from count 20 and kept high through
  // the first four cycles of the following tap.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uo_start) eng_cnt <= 8'd1;
    else if (eng_cnt != 8'd0 && eng_cnt != 8'd255) eng_cnt <= eng_cnt + 8'd1;
    if (eng_cnt == 8'd20) eng_hi <= 1'b1;
    else if (eng_cnt == 8'd4) eng_hi <= 1'b0;
    if (!rst && uo_start) launch_cnt <= launch_cnt + 1;
    if (!rst && wd_done) wd_done_cnt <= wd_done_cnt + 1;
  end

  assign uo_done = eng_level ? ((eng_cnt >= 8'd20) || eng_hi) : (eng_cnt == 8'd20);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_launch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (uo_start === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Runs one sweep and checks every launch against the expected tap set.
  // abort_at > 0 asserts rst during the WAIT of that launch.
  task automatic do_sweep(input string name, input logic [1:0] k, input logic [4:0] oh,
                          input logic [4:0] ow, input logic [4:0] ic,
                          input logic [8:0] mask_in, input logic [8:0] exp_taps,
                          input int abort_at);
    int nlaunch;
    int prev_cyc;
    int base;
    bit ok;
    logic [4:0] e_ih, e_iw;
    nlaunch = 0;
    prev_cyc = 0;
    base = launch_cnt;
    $display("sweep %s k_last=%0d oh_last=%0d ow_last=%0d mask=%b", name, k, oh, ow, mask_in);
    k_last = k; oh_last = oh; ow_last = ow; ic_last = ic;
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
    tap_mask = mask_in;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_first_launch"}, uo_start, 1);
    check({name, "_err_cleared"}, err, 0);
    for (int j = 0; j < 9; j++) begin
      if (!exp_taps[j]) continue;
      wait_launch(ok);
      check({name, "_launch_seen"}, ok, 1);
      e_ih = 5'(j / 3) + oh;
      e_iw = 5'(j % 3) + ow;
      $display("launch %s tap=(%0d,%0d) ih=%0d..%0d iw=%0d..%0d cyc=%0d", name, uo_kh, uo_kw,
               uo_ih_low_start, uo_ih_low_last, uo_iw_low_start, uo_iw_low_last, cyc);
      check({name, "_kh"}, uo_kh, j / 3);
      check({name, "_kw"}, uo_kw, j % 3);
      check({name, "_ih_start"}, uo_ih_low_start, j / 3);
      check({name, "_ih_last"}, uo_ih_low_last, e_ih);
      check({name, "_iw_start"}, uo_iw_low_start, j % 3);
      check({name, "_iw_last"}, uo_iw_low_last, e_iw);
      check({name, "_ic_last"}, uo_ic_last, ic);
      if (nlaunch > 0) check({name, "_interval"}, cyc - prev_cyc, 22);
      prev_cyc = cyc;
      nlaunch++;
      if (nlaunch == abort_at) begin
        repeat (5) @(negedge clk);
        check({name, "_busy_before_rst"}, busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check({name, "_rst_busy"}, busy, 0);
        check({name, "_rst_ustart"}, uo_start, 0);
        check({name, "_rst_done"}, done, 0);
        check({name, "_rst_err"}, err, 0);
        check({name, "_rst_tap"}, {uo_kh, uo_kw}, 0);
        check({name, "_rst_win"}, {uo_ih_low_start, uo_ih_low_last,
                                   uo_iw_low_start, uo_iw_low_last}, 0);
        rst = 1'b0;
        base = launch_cnt;
        repeat (30) @(negedge clk);
        check({name, "_no_launch_after_rst"}, launch_cnt, base);
        return;
      end
      @(negedge clk);
      if (nlaunch == 2) begin
        // start while busy, with a different config, must be ignored
        check({name, "_busy_mid"}, busy, 1);
        start = 1'b1; oh_last = ~oh;
        @(negedge clk);
        start = 1'b0; oh_last = oh;
      end
    end
    wait_done(ok);
    check({name, "_done_seen"}, ok, 1);
    check({name, "_done_latency"}, cyc - prev_cyc, 22);
    @(negedge clk);
    check({name, "_done_single"}, done, 0);
    check({name, "_idle_after"}, busy, 0);
    check({name, "_launch_count"}, launch_cnt - base, $countones(exp_taps));
  endtask

  task automatic try_illegal(input string name, input logic [1:0] k, input logic [4:0] oh,
                             input logic [4:0] ow);
    int base;
    base = launch_cnt;
    $display("illegal %s k_last=%0d oh_last=%0d ow_last=%0d", name, k, oh, ow);
    k_last = k; oh_last = oh; ow_last = ow;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_err"}, err, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_ustart"}, uo_start, 0);
    repeat (3) @(negedge clk);
    check({name, "_no_launch"}, launch_cnt, base);
  endtask

  initial begin
    int l_cyc;
    bit ok;
    repeat (2) @(negedge clk);
    check("reset_ustart", uo_start, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_tap", {uo_kh, uo_kw}, 0);
    check("reset_win", {uo_ih_low_start, uo_ih_low_last, uo_iw_low_start, uo_iw_low_last}, 0);
    rst = 1'b0;
    @(negedge clk);

    do_sweep("s3x3", 2'd2, 5'd7, 5'd7, 5'd3, 9'h1FF, 9'h1FF, 0);
    do_sweep("s1x1", 2'd0, 5'd7, 5'd7, 5'd3, 9'h1FF, 9'b000000001, 0);
    try_illegal("ill_oh", 2'd2, 5'd30, 5'd7);
    do_sweep("after_ill", 2'd0, 5'd7, 5'd7, 5'd1, 9'h1FF, 9'b000000001, 0);
    try_illegal("ill_ow", 2'd1, 5'd0, 5'd31);
    do_sweep("edge_k1", 2'd1, 5'd30, 5'd0, 5'd2, 9'h1FF, 9'b000011011, 0);
    try_illegal("ill_k3", 2'd3, 5'd0, 5'd0);
    eng_level = 1'b1;
    do_sweep("stuck_hi", 2'd2, 5'd7, 5'd7, 5'd3, 9'h1FF, 9'h1FF, 4);
    eng_level = 1'b0;
`ifdef CONV_TAP_SCHED_TAP_MASK_EN
    do_sweep("mask_diag", 2'd2, 5'd7, 5'd7, 5'd3, 9'b100010000, 9'b100010001, 0);
    do_sweep("mask_k1", 2'd1, 5'd7, 5'd7, 5'd3, 9'b111111110, 9'b000011011, 0);
`endif

    // Watchdog instance: engine never answers -> timeout after 15 WAIT cycles
    k_last = 2'd0; oh_last = 5'd7; ow_last = 5'd7; ic_last = 5'd3;
    wd_start = 1'b1;
    @(negedge clk);
    wd_start = 1'b0;
    l_cyc = cyc;
    $display("wd launch tap=(%0d,%0d) cyc=%0d", wd_uo_kh, wd_uo_kw, cyc);
    check("wd_launch", wd_uo_start, 1);
    check("wd_tap", {wd_uo_kh, wd_uo_kw}, 0);
    check("wd_win", {wd_ih_start, wd_ih_last, wd_iw_start, wd_iw_last},
          {5'd0, 5'd7, 5'd0, 5'd7});
    check("wd_ic_last", wd_ic_last, 3);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wd_busy === 1'b0) begin ok = 1'b1; break; end
    end
    check("wd_returned_idle", ok, 1);
    check("wd_timeout_latency", cyc - l_cyc, 16);
    check("wd_err_set", wd_err, 1);
    check("wd_no_done", wd_done_cnt, 0);

    // Completion on the terminal-count cycle wins over the timeout
    wd_start = 1'b1;
    @(negedge clk);
    wd_start = 1'b0;
    $display("wd launch tap=(%0d,%0d) cyc=%0d", wd_uo_kh, wd_uo_kw, cyc);
    check("wd2_launch", wd_uo_start, 1);
    check("wd2_err_cleared", wd_err, 0);
    repeat (15) @(negedge clk);
    check("wd2_busy_term", wd_busy, 1);
    wd_uo_done = 1'b1;
    @(negedge clk);
    check("wd2_busy_next", wd_busy, 1);
    check("wd2_no_err", wd_err, 0);
    @(negedge clk);
    check("wd2_done", wd_done, 1);
    @(negedge clk);
    wd_uo_done = 1'b0;
    check("wd2_idle", wd_busy, 0);
    check("wd2_err_final", wd_err, 0);
    check("wd2_done_count", wd_done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
